mul_2203_seq: RTL and testbench

//  Sequential shift-add multiplier for the mod-2203 datapath. Takes two residues
//  a, b < 2203 and produces their full 23-bit product. The product drives din_a of
//  the combinational mod-2203 Barrett reducer directly downstream.

---
 rtl/mul_2203_seq.sv | 146 ++++++++++++++
 tb/tb_mul_2203_seq.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/mul_2203_seq.sv
// rtl/mul_2203_seq.sv - 12x12 shift-add multiplier feeding the mod-2203 Barrett reducer
// Optional feature macro: OPERAND_CHECK_EN (adds err port and operand >= Q correction)
module mul_2203_seq #(
  parameter int OPW = 12,
  parameter int PW  = 23
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [OPW-1:0] in_a,
  input  logic [OPW-1:0] in_b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [PW-1:0]  out_prod
`ifdef OPERAND_CHECK_EN
  ,
  output logic           err
`endif
);

  localparam int CW = $clog2(OPW + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q,   cnt_d;
  logic [PW-1:0]   acc_q,   acc_d;
  logic [PW-1:0]   a_q,     a_d;
  logic [OPW-1:0]  b_q,     b_d;
  logic [PW-1:0]   prod_q,  prod_d;

  logic [OPW-1:0]  a_fix;
  logic [OPW-1:0]  b_fix;
  logic [PW-1:0]   acc_sum;

`ifdef OPERAND_CHECK_EN
  localparam int Q = 2203;
  localparam logic [OPW-1:0] QV = OPW'(Q);

  logic err_q, err_d;
  logic a_bad, b_bad;

  // Fold out-of-range operands back below Q; one subtraction suffices as 2^OPW-1 < 2Q.
  always_comb begin
    a_bad = (in_a >= QV);
    b_bad = (in_b >= QV);
    a_fix = a_bad ? (in_a - QV) : in_a;
    b_fix = b_bad ? (in_b - QV) : in_b;
  end

  assign err = err_q;
`else
  // Operands are latched exactly as presented.
  always_comb begin
    a_fix = in_a;
    b_fix = in_b;
  end
`endif

  // Partial-product accumulate for the current multiplier bit.
  always_comb begin
    acc_sum = b_q[0] ? (acc_q + a_q) : acc_q;
  end

  // State and datapath registers; reset discards any in-flight operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      prod_q  <= '0;
`ifdef OPERAND_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      a_q     <= a_d;
      b_q     <= b_d;
      prod_q  <= prod_d;
`ifdef OPERAND_CHECK_EN
      err_q   <= err_d;
`endif
    end
  end

  // Next-state and handshake decode; handshake outputs depend on state only.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    a_d       = a_q;
    b_d       = b_q;
    prod_d    = prod_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
`ifdef OPERAND_CHECK_EN
    err_d     = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          a_d     = {{(PW-OPW){1'b0}}, a_fix};
          b_d     = b_fix;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = S_BUSY;
`ifdef OPERAND_CHECK_EN
          err_d   = a_bad | b_bad;
`endif
        end
      end
      S_BUSY: begin
        acc_d = acc_sum;
        a_d   = a_q << 1;
        b_d   = b_q >> 1;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(OPW - 1)) begin
          prod_d  = acc_sum;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign out_prod = prod_q;

endmodule

// File: tb/tb_mul_2203_seq.sv
// tb/tb_mul_2203_seq.sv - directed and randomized self-checking bench for mul_2203_seq
module tb_mul_2203_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] in_a;
  logic [11:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [22:0] out_prod;
`ifdef OPERAND_CHECK_EN
  logic        err;
`endif

  int checks = 0;
  int errors = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  mul_2203_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_prod  (out_prod)
`ifdef OPERAND_CHECK_EN
    ,
    .err       (err)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input int a, input int b);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      tick;
      n++;
    end
    chk("accept_ready", {31'd0, in_ready}, 1);
    in_a = 12'(a);
    in_b = 12'(b);
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat, output int rdy_seen);
    lat = 0;
    rdy_seen = 0;
    while (!out_valid && lat < 60) begin
      if (in_ready) rdy_seen++;
      tick;
      lat++;
    end
    chk("valid_timeout", {31'd0, out_valid}, 1);
  endtask

  task automatic run_op(input int a, input int b, input int exp, input bit keep_rdy);
    int lat;
    int rdy;
    accept(a, b);
    wait_valid(lat, rdy);
    chk("latency", lat, 12);
    chk("in_ready_busy", rdy, 0);
    chk("prod", {9'd0, out_prod}, exp);
    chk("in_ready_done", {31'd0, in_ready}, 0);
    out_ready = 1'b1;
    tick;
    if (!keep_rdy) out_ready = 1'b0;
    chk("valid_drop", {31'd0, out_valid}, 0);
    chk("idle_ready", {31'd0, in_ready}, 1);
  endtask

  initial begin
    int lat;
    int rdy;
    int a;
    int b;
    int gap;
    int stall;
    int bad;
    int exp;

    rst = 1'b1;
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    out_ready = 1'b0;
    tick;
    tick;
    rst = 1'b0;
    chk("rst_in_ready", {31'd0, in_ready}, 1);
    chk("rst_out_valid", {31'd0, out_valid}, 0);
    chk("rst_out_prod", {9'd0, out_prod}, 0);
`ifdef OPERAND_CHECK_EN
    chk("rst_err", {31'd0, err}, 0);
`endif

    // Largest residues: exact product, 12-edge latency
    run_op(2202, 2202, 2202 * 2202, 1'b0);

    // Back-to-back with out_ready held high
    out_ready = 1'b1;
    run_op(0, 1234, 0, 1'b1);
    run_op(1, 2202, 2202, 1'b1);
    run_op(1234, 567, 699678, 1'b1);
    out_ready = 1'b0;

    // Backpressure in DONE with an ignored in_valid pulse
    accept(1000, 2000);
    wait_valid(lat, rdy);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        in_a = 12'd7;
        in_b = 12'd9;
        in_valid = 1'b1;
      end
      tick;
      in_valid = 1'b0;
      if (out_valid !== 1'b1 || out_prod !== 23'd2000000 || in_ready !== 1'b0) bad++;
    end
    chk("hold_done", bad, 0);
    chk("hold_prod", {9'd0, out_prod}, 2000000);
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    chk("hold_release_valid", {31'd0, out_valid}, 0);
    chk("hold_release_idle", {31'd0, in_ready}, 1);
    tick;
    chk("pulse_ignored", {31'd0, in_ready}, 1);

    // Reset in the middle of BUSY discards the operation
    accept(2202, 2202);
    repeat (5) tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("midrst_valid", {31'd0, out_valid}, 0);
    chk("midrst_prod", {9'd0, out_prod}, 0);
    chk("midrst_ready", {31'd0, in_ready}, 1);
    run_op(3, 5, 15, 1'b0);

`ifdef OPERAND_CHECK_EN
    run_op(2205, 3, 6, 1'b0);
    chk("err_set", {31'd0, err}, 1);
    accept(4, 5);
    wait_valid(lat, rdy);
    chk("err_prod", {9'd0, out_prod}, 20);
    chk("err_clear", {31'd0, err}, 0);
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
`endif

    // Random residues with random input gaps and output stalls
    for (int i = 0; i < 1500; i++) begin
      a = $urandom_range(0, 2202);
      b = $urandom_range(0, 2202);
      gap = $urandom_range(0, 2);
      repeat (gap) tick;
      accept(a, b);
      exp_q.push_back(a * b);
      wait_valid(lat, rdy);
      chk("rnd_latency", lat, 12);
      stall = $urandom_range(0, 3);
      exp = exp_q.pop_front();
      bad = 0;
      for (int s = 0; s < stall; s++) begin
        tick;
        if (out_valid !== 1'b1 || out_prod !== 23'(exp)) bad++;
      end
      chk("rnd_stall", bad, 0);
      chk("rnd_prod", {9'd0, out_prod}, exp);
      chk("rnd_mod", ({9'd0, out_prod}) % 2203, exp % 2203);
      out_ready = 1'b1;
      tick;
      out_ready = 1'b0;
      chk("rnd_no_dup", {31'd0, out_valid}, 0);
    end
    chk("rnd_queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
